// File: rtl/key_repeater_if.sv
// Key-repeater signal bundle: debounced edge pulses in, move/held out.
// The slave side is the repeater; the master side is whoever feeds it key edges.
interface key_repeater_if;
  logic key_down;
  logic key_up;
  logic move;
  logic held;

  modport master (
    output key_down,
    output key_up,
    input  move,
    input  held
  );

  modport slave (
    input  key_down,
    input  key_up,
    output move,
    output held
  );
endinterface

// File: rtl/key_repeater.sv
// Hold-to-repeat (delayed auto-shift): immediate move, one long delay, then periodic repeats.
// Optional KEY_REPEAT_ACCEL_EN halves the repeat period after the 8th repeat pulse.
module key_repeater #(
  parameter int unsigned DELAY_CYCLES  = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 12_500_000
) (
  input  logic           clk,
  input  logic           rst,
  key_repeater_if.slave  kif
);

  localparam logic [31:0] DELAY_LAST = 32'(DELAY_CYCLES - 1);
  localparam logic [31:0] REP_LAST   = 32'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        move_q, move_d;
  logic        held_q, held_d;
  logic [31:0] period_last;

`ifdef KEY_REPEAT_ACCEL_EN
  localparam logic [31:0] REP_HALF_LAST = 32'((REPEAT_CYCLES >> 1) - 1);
  logic [7:0] rcnt_q, rcnt_d;

  assign period_last = (rcnt_q >= 8'd8) ? REP_HALF_LAST : REP_LAST;
`else
  assign period_last = REP_LAST;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    move_d  = 1'b0;
`ifdef KEY_REPEAT_ACCEL_EN
    rcnt_d  = rcnt_q;
`endif
    case (state_q)
      IDLE: begin
        // a simultaneous release cancels the press
        if (kif.key_down && !kif.key_up) begin
          move_d  = 1'b1;
          state_d = DELAY;
          cnt_d   = '0;
`ifdef KEY_REPEAT_ACCEL_EN
          rcnt_d  = '0;
`endif
        end
      end
      DELAY: begin
        if (kif.key_up) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DELAY_LAST) begin
          move_d  = 1'b1;
          state_d = REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      REPEAT: begin
        if (kif.key_up) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == period_last) begin
          move_d = 1'b1;
          cnt_d  = '0;
`ifdef KEY_REPEAT_ACCEL_EN
          if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
`endif
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      move_q  <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEY_REPEAT_ACCEL_EN
      rcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      move_q  <= move_d;
      held_q  <= held_d;
`ifdef KEY_REPEAT_ACCEL_EN
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  assign kif.move = move_q;
  assign kif.held = held_q;

endmodule
